// File: rtl/nmea_frame_parser_if.sv
// Character input and frame/payload output bundle for the NMEA sentence parser.
interface nmea_frame_parser_if #(
    parameter int unsigned ADDR_W = 7
);
    logic              i_valid;
    logic [7:0]        i_char;
    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [7:0]        o_wr_data;
    logic              o_busy;
    logic              o_done;
    logic              o_ok;
    logic [2:0]        o_err;
    logic [ADDR_W-1:0] o_len;
    logic [15:0]       o_talker;
    logic [23:0]       o_sentence;

    modport master (
        output i_valid, i_char,
        input  o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_ok, o_err,
               o_len, o_talker, o_sentence
    );

    modport slave (
        input  i_valid, i_char,
        output o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_ok, o_err,
               o_len, o_talker, o_sentence
    );
endinterface

// File: rtl/nmea_frame_parser.sv
// NMEA-0183 sentence parser: splits talker/sentence IDs, streams payload bytes,
// verifies XOR checksum and CR/LF terminator, and reports a per-frame status.
module nmea_frame_parser #(
    parameter int unsigned MAX_LEN      = 80,
    parameter int unsigned ADDR_W       = 7,
    parameter int unsigned REQUIRE_CRLF = 1,
    parameter int unsigned CKSUM_OPT    = 0,
    parameter int unsigned ACCEPT_LOWER = 0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    nmea_frame_parser_if.slave  bus
);
    localparam logic [7:0] C_DOLLAR = 8'h24;
    localparam logic [7:0] C_STAR   = 8'h2A;
    localparam logic [7:0] C_CR     = 8'h0D;
    localparam logic [7:0] C_LF     = 8'h0A;

    typedef enum logic [2:0] {S_IDLE, S_TI, S_SI, S_DATA, S_CK, S_CR, S_LF} state_t;

    state_t            state_q, state_d;
    logic [7:0]        xor_q, xor_d;
    logic [7:0]        ck_q, ck_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic              nock_q, nock_d;
    logic [15:0]       tk_q, tk_d;
    logic [23:0]       se_q, se_d;

    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ok_q, ok_d;
    logic [2:0]        err_q, err_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [15:0]       talker_q, talker_d;
    logic [23:0]       sentence_q, sentence_d;

    logic              fin;
    logic [2:0]        fin_err;
    logic [4:0]        hex;

    // Returns {valid, nibble} for a checksum digit.
    function automatic logic [4:0] hex_dec(input logic [7:0] c);
        logic [7:0] t;
        t = 8'h00;
        if (c >= 8'h30 && c <= 8'h39) begin
            t = c - 8'h30;
            return {1'b1, t[3:0]};
        end
        if (c >= 8'h41 && c <= 8'h46) begin
            t = c - 8'h37;
            return {1'b1, t[3:0]};
        end
        if (ACCEPT_LOWER != 0 && c >= 8'h61 && c <= 8'h66) begin
            t = c - 8'h57;
            return {1'b1, t[3:0]};
        end
        return 5'd0;
    endfunction

    always_comb begin
        state_d    = state_q;
        xor_d      = xor_q;
        ck_d       = ck_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        nock_d     = nock_q;
        tk_d       = tk_q;
        se_d       = se_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        ok_d       = ok_q;
        err_d      = err_q;
        len_d      = len_q;
        talker_d   = talker_q;
        sentence_d = sentence_q;
        fin        = 1'b0;
        fin_err    = 3'd0;
        hex        = hex_dec(bus.i_char);

        if (bus.i_valid) begin
            if (bus.i_char == C_DOLLAR) begin
                // '$' always opens a new frame; an open one is aborted as a restart
                if (state_q != S_IDLE) begin
                    fin     = 1'b1;
                    fin_err = 3'd5;
                end
                state_d = S_TI;
                xor_d   = 8'h00;
                ck_d    = 8'h00;
                cnt_d   = '0;
                idx_d   = 2'd0;
                nock_d  = 1'b0;
                tk_d    = 16'h0000;
                se_d    = 24'h000000;
            end else begin
                unique case (state_q)
                    S_IDLE: ;
                    S_TI, S_SI: begin
                        if (bus.i_char == C_STAR || bus.i_char == C_CR || bus.i_char == C_LF) begin
                            fin     = 1'b1;
                            fin_err = 3'd4;
                            state_d = S_IDLE;
                        end else begin
                            xor_d = xor_q ^ bus.i_char;
                            idx_d = idx_q + 2'd1;
                            if (state_q == S_TI) begin
                                if (idx_q == 2'd0) tk_d[15:8] = bus.i_char;
                                else               tk_d[7:0]  = bus.i_char;
                                if (idx_q == 2'd1) begin
                                    state_d = S_SI;
                                    idx_d   = 2'd0;
                                end
                            end else begin
                                if (idx_q == 2'd0)      se_d[23:16] = bus.i_char;
                                else if (idx_q == 2'd1) se_d[15:8]  = bus.i_char;
                                else                    se_d[7:0]   = bus.i_char;
                                if (idx_q == 2'd2) begin
                                    state_d = S_DATA;
                                    idx_d   = 2'd0;
                                end
                            end
                        end
                    end
                    S_DATA: begin
                        if (bus.i_char == C_STAR) begin
                            state_d = S_CK;
                            idx_d   = 2'd0;
                        end else if (bus.i_char == C_CR) begin
                            if (CKSUM_OPT != 0) begin
                                state_d = S_LF;
                                nock_d  = 1'b1;
                            end else begin
                                fin     = 1'b1;
                                fin_err = 3'd6;
                                state_d = S_IDLE;
                            end
                        end else if (cnt_q == ADDR_W'(MAX_LEN)) begin
                            fin     = 1'b1;
                            fin_err = 3'd3;
                            state_d = S_IDLE;
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = cnt_q;
                            wr_data_d = bus.i_char;
                            cnt_d     = cnt_q + ADDR_W'(1);
                            xor_d     = xor_q ^ bus.i_char;
                        end
                    end
                    S_CK: begin
                        if (!hex[4]) begin
                            fin     = 1'b1;
                            fin_err = 3'd2;
                            state_d = S_IDLE;
                        end else if (idx_q == 2'd0) begin
                            ck_d[7:4] = hex[3:0];
                            idx_d     = 2'd1;
                        end else begin
                            ck_d[3:0] = hex[3:0];
                            if (REQUIRE_CRLF != 0) begin
                                state_d = S_CR;
                            end else begin
                                fin     = 1'b1;
                                fin_err = ({ck_q[7:4], hex[3:0]} != xor_q) ? 3'd1 : 3'd0;
                                state_d = S_IDLE;
                            end
                        end
                    end
                    S_CR: begin
                        if (bus.i_char == C_CR) begin
                            state_d = S_LF;
                        end else begin
                            fin     = 1'b1;
                            fin_err = 3'd4;
                            state_d = S_IDLE;
                        end
                    end
                    S_LF: begin
                        fin     = 1'b1;
                        state_d = S_IDLE;
                        if (bus.i_char != C_LF)  fin_err = 3'd4;
                        else if (!nock_q && ck_q != xor_q) fin_err = 3'd1;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end

        // Frame status is published only when a frame ends or aborts
        if (fin) begin
            done_d     = 1'b1;
            err_d      = fin_err;
            ok_d       = (fin_err == 3'd0);
            len_d      = cnt_q;
            talker_d   = tk_q;
            sentence_d = se_q;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= S_IDLE;
            xor_q      <= 8'h00;
            ck_q       <= 8'h00;
            cnt_q      <= '0;
            idx_q      <= 2'd0;
            nock_q     <= 1'b0;
            tk_q       <= 16'h0000;
            se_q       <= 24'h000000;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= 3'd0;
            len_q      <= '0;
            talker_q   <= 16'h0000;
            sentence_q <= 24'h000000;
        end else begin
            state_q    <= state_d;
            xor_q      <= xor_d;
            ck_q       <= ck_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            nock_q     <= nock_d;
            tk_q       <= tk_d;
            se_q       <= se_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
            len_q      <= len_d;
            talker_q   <= talker_d;
            sentence_q <= sentence_d;
        end
    end

    assign bus.o_wr_en    = wr_en_q;
    assign bus.o_wr_addr  = wr_addr_q;
    assign bus.o_wr_data  = wr_data_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_done     = done_q;
    assign bus.o_ok       = ok_q;
    assign bus.o_err      = err_q;
    assign bus.o_len      = len_q;
    assign bus.o_talker   = talker_q;
    assign bus.o_sentence = sentence_q;
endmodule
